// File: rtl/load_store_unit.sv
// RV32I load/store requester for a word-wide memory with a combinational read port.
// Sub-word stores are done as read-modify-write; every request gets exactly one response.
module load_store_unit #(
  parameter int WORD_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_store,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [WORD_ADDR_W-1:0] mem_write_addr,
  output logic [31:0]            mem_write_data,
  output logic                   mem_we,
  output logic [WORD_ADDR_W-1:0] mem_read_addr,
  input  logic [31:0]            mem_read_data
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             lane_q, lane_d;
  logic [WORD_ADDR_W-1:0] index_q, index_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   req_err;

  function automatic logic access_error(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic bad_f3, misalign, oor;
    bad_f3   = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    misalign = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    oor      = |(a >> (WORD_ADDR_W + 2));
    return bad_f3 | misalign | oor;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Only the addressed lane changes; the other bytes keep what memory returned.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] lane, input logic [2:0] f3);
    logic [31:0] r;
    r = w;
    if (f3 == 3'd0) begin
      case (lane)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (f3 == 3'd1) begin
      if (lane[1]) r[31:16] = d[15:0];
      else         r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  assign accept  = req_valid & req_ready;
  assign req_err = access_error(req_is_store, req_funct3, req_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      lane_q   <= 2'd0;
      index_q  <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
      index_q  <= index_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                  state_d = S_RESP;
          else if (!req_is_store)       state_d = S_LOAD;
          else if (req_funct3 == 3'd2)  state_d = S_WRITE;
          else                          state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    funct3_d = funct3_q;
    lane_d   = lane_q;
    index_d  = index_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (state_q == S_IDLE && accept) begin
      funct3_d = req_funct3;
      lane_d   = req_addr[1:0];
      index_d  = req_addr[WORD_ADDR_W+1:2];
      wdata_d  = req_wdata;
      rdata_d  = 32'd0;
      err_d    = req_err;
    end else if (state_q == S_LOAD) begin
      rdata_d = load_extend(mem_read_data, lane_q, funct3_q);
    end else if (state_q == S_RMW_RD) begin
      wdata_d = store_merge(mem_read_data, wdata_q, lane_q, funct3_q);
    end
  end

  always_comb begin
    req_ready      = (state_q == S_IDLE) & ~rst;
    rsp_valid      = (state_q == S_RESP);
    rsp_rdata      = rdata_q;
    rsp_err        = err_q;
    mem_we         = (state_q == S_WRITE) & ~rst;
    mem_write_addr = index_q;
    mem_write_data = wdata_q;
    mem_read_addr  = index_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back sequences,
// then random traffic checked against a byte-addressed memory model.
module tb_load_store_unit;

  localparam int WORD_ADDR_W = 5;
  localparam int NWORDS      = 32;
  localparam int NBYTES      = 128;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_is_store;
  logic [2:0]             req_funct3;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic [WORD_ADDR_W-1:0] mem_write_addr;
  logic [31:0]            mem_write_data;
  logic                   mem_we;
  logic [WORD_ADDR_W-1:0] mem_read_addr;
  logic [31:0]            mem_read_data;

  logic [31:0] tb_mem [NWORDS];
  bit   [7:0]  ref_mem [NBYTES];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_ADDR_W(WORD_ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data), .mem_we(mem_we),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = tb_mem[mem_read_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_write_addr] <= mem_write_data;

  typedef struct {
    bit        st;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp_rdata;
    bit        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: little-endian bytes, sizes and legality from the RV32I rules.
  task automatic ref_access(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                            input bit [31:0] wdata, output bit [31:0] rdata, output bit err);
    int     size;
    bit     legal;
    longint val;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    err   = !legal || (addr % size != 0) || (addr >= NBYTES);
    rdata = 32'd0;
    if (!err) begin
      if (st) begin
        for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < size; i++) val += longint'(ref_mem[addr + i]) << (8*i);
        if (f3 < 4 && size < 4 && val >= (longint'(1) << (8*size - 1)))
          val -= (longint'(1) << (8*size));
        rdata = val[31:0];
      end
    end
  endtask

  function automatic int exp_latency(input bit err, input bit st, input bit [2:0] f3);
    if (err) return 1;
    if (!st || f3 == 3'd2) return 2;
    return 3;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_txn(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wdata, output bit [31:0] rdata, output bit err,
                        output int lat, output int we_cnt, output bit got);
    rdata = 32'd0; err = 1'b0; lat = 0; we_cnt = 0; got = 1'b0;
    wait_ready();
    req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (rsp_valid) begin
        got = 1'b1; lat = c; rdata = rsp_rdata; err = rsp_err;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input bit st, input bit [2:0] f3,
                               input bit [31:0] addr, input bit [31:0] wdata,
                               input bit [31:0] exp_rdata, input bit exp_err);
    bit [31:0] rdata;
    bit        err, got;
    int        lat, we_cnt;
    do_txn(st, f3, addr, wdata, rdata, err, lat, we_cnt, got);
    check({tag, " rsp_seen"}, 32'(got), 32'd1);
    check({tag, " rdata"}, rdata, exp_rdata);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " latency"}, 32'(lat), 32'(exp_latency(exp_err, st, f3)));
    check({tag, " we_count"}, 32'(we_cnt), 32'((st && !exp_err) ? 1 : 0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] rd, w;
    bit        er, bad;
    bit [31:0] exp_q[$];
    int        idx, rsp_cnt;
    bit        busy, was_busy, ready_ok;
    bit        st;
    bit [2:0]  f3;
    bit [31:0] addr;

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < NWORDS; i++) begin
      tb_mem[i] = 32'(4*i + 1);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = tb_mem[i][8*b +: 8];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset waddr", 32'(mem_write_addr), 32'd0);
    check("reset wdata", mem_write_data, 32'd0);
    check("reset raddr", 32'(mem_read_addr), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 check("ready after reset", 32'(req_ready), 32'd1);

    vecs[0]  = '{1'b0, 3'd2, 32'h04, 32'h0,        32'h00000005, 1'b0};
    vecs[1]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{1'b0, 3'd4, 32'h12, 32'h0,        32'h000000AD, 1'b0};
    vecs[4]  = '{1'b0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[5]  = '{1'b0, 3'd1, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[6]  = '{1'b1, 3'd0, 32'h11, 32'h12345677, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEAD77EF, 1'b0};
    vecs[8]  = '{1'b0, 3'd2, 32'h06, 32'h0,        32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 3'd1, 32'h03, 32'h0000FFFF, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 32'h80, 32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 3'd3, 32'h00, 32'h0,        32'h00000000, 1'b1};

    for (int v = 0; v < 12; v++) begin
      ref_access(vecs[v].st, vecs[v].f3, vecs[v].addr, vecs[v].wdata, rd, er);
      run_and_check($sformatf("vec%0d", v), vecs[v].st, vecs[v].f3, vecs[v].addr,
                    vecs[v].wdata, vecs[v].exp_rdata, vecs[v].exp_err);
    end
    check("word4 after SB", tb_mem[4], 32'hDEAD77EF);

    // Reset while the SB is in its read phase: the access must vanish.
    wait_ready();
    req_is_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h000000AA;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rmw reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("rmw reset ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 check("rmw ready after rst", 32'(req_ready), 32'd1);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || mem_we) bad = 1'b1;
    end
    check("rmw reset quiet", 32'(bad), 32'd0);
    check("rmw reset word4", tb_mem[4], 32'hDEAD77EF);

    // Reset raised while WRITE is active: the write enable must drop immediately.
    wait_ready();
    req_is_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h14; req_wdata = 32'h11111111;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("write state we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1 check("we gated by rst", 32'(mem_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("word5 untouched", tb_mem[5], 32'h00000015);

    // Back-to-back with req_valid held high.
    idx = 0; rsp_cnt = 0; busy = 1'b0; ready_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      was_busy = busy;
      if (req_ready !== !busy) ready_ok = 1'b0;
      if (rsp_valid) begin
        rsp_cnt++;
        if (exp_q.size() > 0) check("b2b rdata", rsp_rdata, exp_q.pop_front());
        busy = 1'b0;
      end
      if (!was_busy) begin
        if (idx < 3) begin
          case (idx)
            0:       begin st = 1'b1; f3 = 3'd2; addr = 32'h20; w = 32'hCAFEF00D; end
            1:       begin st = 1'b0; f3 = 3'd2; addr = 32'h20; w = 32'h0; end
            default: begin st = 1'b0; f3 = 3'd5; addr = 32'h22; w = 32'h0; end
          endcase
          req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = w;
          req_valid = 1'b1;
          ref_access(st, f3, addr, w, rd, er);
          exp_q.push_back(rd);
          busy = 1'b1;
          idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b responses", 32'(rsp_cnt), 32'd3);
    check("b2b ready tracking", 32'(ready_ok), 32'd1);
    check("b2b last half", 32'(exp_q.size()), 32'd0);

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      else    f3 = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
      w = $urandom;
      ref_access(st, f3, addr, w, rd, er);
      run_and_check($sformatf("rand%0d", n), st, f3, addr, w, rd, er);
    end

    for (int i = 0; i < NWORDS; i++) begin
      w = {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]};
      check($sformatf("final word%0d", i), tb_mem[i], w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
